// File: rtl/gbc_sound_mixer.sv
// Time-multiplexed stereo mixer: snapshots channel samples and NR50/51/52 controls on a strobe,
// accumulates the panned channels one per cycle, then applies master volume and saturation.
module gbc_sound_mixer #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 20
) (
  input  logic                         I_CLK,
  input  logic                         I_RESET_L,
  input  logic                         I_STROBE,
  input  logic [NUM_CH*SAMPLE_W-1:0]   I_CH_SAMPLES,
  input  logic [NUM_CH-1:0]            I_PAN_SO1,
  input  logic [NUM_CH-1:0]            I_PAN_SO2,
  input  logic [2:0]                   I_SO1_VOL,
  input  logic [2:0]                   I_SO2_VOL,
  input  logic                         I_SO1_EN,
  input  logic                         I_SO2_EN,
  input  logic                         I_MASTER_EN,
  input  logic                         I_CLR_OVERRUN,
  output logic [SAMPLE_W-1:0]          O_SO1,
  output logic [SAMPLE_W-1:0]          O_SO2,
  output logic                         O_VALID,
  output logic                         O_BUSY,
  output logic                         O_OVERRUN
);

  localparam int ACC_W  = SAMPLE_W + $clog2(NUM_CH) + 1;
  localparam int PROD_W = ACC_W + 4;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX =
    signed'({{(PROD_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}});
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    signed'({{(PROD_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}});

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                      state_r;
  state_t                      state_next_s;
  logic [IDX_W-1:0]            idx_r;
  logic signed [SAMPLE_W-1:0]  samp_r [NUM_CH];
  logic [NUM_CH-1:0]           pan1_r;
  logic [NUM_CH-1:0]           pan2_r;
  logic [2:0]                  vol1_r;
  logic [2:0]                  vol2_r;
  logic                        en1_r;
  logic                        en2_r;
  logic signed [ACC_W-1:0]     acc1_r;
  logic signed [ACC_W-1:0]     acc2_r;
  logic [SAMPLE_W-1:0]         res1_r;
  logic [SAMPLE_W-1:0]         res2_r;

  // Gain of (vol+1)/8 with floor rounding, clamped to the output range; a disabled terminal gives 0.
  function automatic logic [SAMPLE_W-1:0] scale_sat(
    input logic signed [ACC_W-1:0] acc,
    input logic [2:0]              vol,
    input logic                    en
  );
    logic [3:0]               gain;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic [SAMPLE_W-1:0]      result;
    gain    = {1'b0, vol} + 4'd1;
    prod    = PROD_W'(acc) * signed'(PROD_W'(gain));
    shifted = prod >>> 3;
    if (!en) begin
      result = {SAMPLE_W{1'b0}};
    end else if (shifted > SAT_MAX) begin
      result = SAT_MAX[SAMPLE_W-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      result = shifted[SAMPLE_W-1:0];
    end
    return result;
  endfunction

  // State register.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (I_STROBE) begin
          state_next_s = ST_ACCUM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (idx_r == IDX_LAST) begin
          state_next_s = ST_SCALE;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_SCALE: state_next_s = ST_DONE;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Snapshot, accumulate, scale and output registers.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      idx_r   <= {IDX_W{1'b0}};
      pan1_r  <= {NUM_CH{1'b0}};
      pan2_r  <= {NUM_CH{1'b0}};
      vol1_r  <= 3'd0;
      vol2_r  <= 3'd0;
      en1_r   <= 1'b0;
      en2_r   <= 1'b0;
      acc1_r  <= {ACC_W{1'b0}};
      acc2_r  <= {ACC_W{1'b0}};
      res1_r  <= {SAMPLE_W{1'b0}};
      res2_r  <= {SAMPLE_W{1'b0}};
      O_SO1   <= {SAMPLE_W{1'b0}};
      O_SO2   <= {SAMPLE_W{1'b0}};
      O_VALID <= 1'b0;
      O_BUSY  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        samp_r[k] <= {SAMPLE_W{1'b0}};
      end
    end else begin
      O_VALID <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (I_STROBE) begin
            for (int k = 0; k < NUM_CH; k++) begin
              samp_r[k] <= signed'(I_CH_SAMPLES[k*SAMPLE_W +: SAMPLE_W]);
            end
            pan1_r <= I_PAN_SO1;
            pan2_r <= I_PAN_SO2;
            vol1_r <= I_SO1_VOL;
            vol2_r <= I_SO2_VOL;
            en1_r  <= I_SO1_EN & I_MASTER_EN;
            en2_r  <= I_SO2_EN & I_MASTER_EN;
            acc1_r <= {ACC_W{1'b0}};
            acc2_r <= {ACC_W{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
            O_BUSY <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (pan1_r[idx_r]) begin
            acc1_r <= acc1_r + ACC_W'(samp_r[idx_r]);
          end
          if (pan2_r[idx_r]) begin
            acc2_r <= acc2_r + ACC_W'(samp_r[idx_r]);
          end
          idx_r <= idx_r + IDX_W'(1);
        end
        ST_SCALE: begin
          res1_r <= scale_sat(acc1_r, vol1_r, en1_r);
          res2_r <= scale_sat(acc2_r, vol2_r, en2_r);
        end
        ST_DONE: begin
          O_SO1   <= res1_r;
          O_SO2   <= res2_r;
          O_VALID <= 1'b1;
          O_BUSY  <= 1'b0;
        end
        default: begin
          O_BUSY <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a strobe while busy wins over a same-cycle clear.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      O_OVERRUN <= 1'b0;
    end else if (I_STROBE && (state_r != ST_IDLE)) begin
      O_OVERRUN <= 1'b1;
    end else if (I_CLR_OVERRUN) begin
      O_OVERRUN <= 1'b0;
    end else begin
      O_OVERRUN <= O_OVERRUN;
    end
  end

endmodule

// File: tb/tb_gbc_sound_mixer.sv
// Self-checking bench for gbc_sound_mixer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_gbc_sound_mixer;

  localparam int NUM_CH = 4;
  localparam int SW     = 20;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 strobe = 1'b0;
  logic [NUM_CH*SW-1:0] samples = '0;
  logic [NUM_CH-1:0]    pan1 = '0;
  logic [NUM_CH-1:0]    pan2 = '0;
  logic [2:0]           vol1 = 3'd7;
  logic [2:0]           vol2 = 3'd7;
  logic                 en1 = 1'b1;
  logic                 en2 = 1'b1;
  logic                 men = 1'b1;
  logic                 clr = 1'b0;
  logic [SW-1:0]        so1;
  logic [SW-1:0]        so2;
  logic                 valid;
  logic                 busy;
  logic                 ovr;

  int checks = 0;
  int errors = 0;

  gbc_sound_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SW)) dut (
    .I_CLK(clk), .I_RESET_L(rst_n), .I_STROBE(strobe), .I_CH_SAMPLES(samples),
    .I_PAN_SO1(pan1), .I_PAN_SO2(pan2), .I_SO1_VOL(vol1), .I_SO2_VOL(vol2),
    .I_SO1_EN(en1), .I_SO2_EN(en2), .I_MASTER_EN(men), .I_CLR_OVERRUN(clr),
    .O_SO1(so1), .O_SO2(so2), .O_VALID(valid), .O_BUSY(busy), .O_OVERRUN(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mixed value of one terminal from plain integer arithmetic.
  function automatic longint mix(input logic [NUM_CH*SW-1:0] s, input logic [NUM_CH-1:0] pan,
                                 input logic [2:0] vol, input logic en);
    longint acc = 0;
    longint lim = longint'(1) << (SW - 1);
    for (int k = 0; k < NUM_CH; k++)
      if (pan[k]) acc += longint'($signed(s[k*SW +: SW]));
    acc = acc * (longint'(vol) + 1);
    if (acc < 0) acc = (acc - 7) / 8;
    else acc = acc / 8;
    if (acc > lim - 1) acc = lim - 1;
    if (acc < -lim) acc = -lim;
    return en ? acc : 0;
  endfunction

  function automatic logic [NUM_CH*SW-1:0] pack(input longint c0, input longint c1,
                                               input longint c2, input longint c3);
    logic [NUM_CH*SW-1:0] r;
    r[0*SW +: SW] = c0[SW-1:0];
    r[1*SW +: SW] = c1[SW-1:0];
    r[2*SW +: SW] = c2[SW-1:0];
    r[3*SW +: SW] = c3[SW-1:0];
    return r;
  endfunction

  // Reference model: a pending result plus a count of busy cycles remaining.
  int     busy_left;
  logic   m_valid;
  logic   m_ovr;
  longint m_so1, m_so2, pend1, pend2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left <= 0;
      m_valid   <= 1'b0;
      m_ovr     <= 1'b0;
      m_so1     <= 0;
      m_so2     <= 0;
    end else if (busy_left != 0) begin
      if (strobe) m_ovr <= 1'b1;
      else if (clr) m_ovr <= 1'b0;
      busy_left <= busy_left - 1;
      if (busy_left == 1) begin
        m_valid <= 1'b1;
        m_so1   <= pend1;
        m_so2   <= pend2;
      end else begin
        m_valid <= 1'b0;
      end
    end else begin
      m_valid <= 1'b0;
      if (clr) m_ovr <= 1'b0;
      if (strobe) begin
        pend1     <= mix(samples, pan1, vol1, en1 & men);
        pend2     <= mix(samples, pan2, vol2, en2 & men);
        busy_left <= NUM_CH + 2;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", valid, m_valid);
      chk("busy", busy, busy_left != 0);
      chk("overrun", ovr, m_ovr);
      chk("so1", longint'($signed(so1)), m_so1);
      chk("so2", longint'($signed(so2)), m_so2);
    end
  end

  task automatic do_mix(input string name, input logic [NUM_CH*SW-1:0] s,
                        input logic [3:0] p1, input logic [3:0] p2,
                        input logic [2:0] v1, input logic [2:0] v2,
                        input logic e1, input logic e2, input logic me,
                        input longint x1, input longint x2);
    int lat = 0;
    int nval = 0;
    @(negedge clk);
    samples = s; pan1 = p1; pan2 = p2; vol1 = v1; vol2 = v2;
    en1 = e1; en2 = e2; men = me; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (valid) begin
        nval++;
        if (lat == 0) begin
          lat = i;
          chk({name, "_so1"}, longint'($signed(so1)), x1);
          chk({name, "_so2"}, longint'($signed(so2)), x2);
        end
      end
    end
    chk({name, "_latency"}, lat, 6);
    chk({name, "_pulses"}, nval, 1);
  endtask

  int cnt;

  initial begin
    // Reset held, then released with no strobe.
    repeat (3) @(negedge clk);
    chk("rst_so1", so1, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (valid) cnt++; end
    chk("rst_no_valid", cnt, 0);

    do_mix("route", pack(1000, -300, 0, 0), 4'b0001, 4'b0011, 3'd7, 3'd7, 1, 1, 1, 1000, 700);
    do_mix("so2_off", pack(1000, -300, 0, 0), 4'b0001, 4'b0011, 3'd7, 3'd7, 1, 0, 1, 1000, 0);
    do_mix("master_off", pack(1000, -300, 0, 0), 4'b0001, 4'b0011, 3'd7, 3'd7, 1, 1, 0, 0, 0);
    do_mix("vol3", pack(800, 0, 0, 0), 4'b0001, 4'b0000, 3'd3, 3'd7, 1, 1, 1, 400, 0);
    do_mix("vol0", pack(-800, 0, 0, 0), 4'b0001, 4'b0000, 3'd0, 3'd7, 1, 1, 1, -100, 0);
    do_mix("sat_pos", pack(400000, 400000, 400000, 400000), 4'b1111, 4'b1111,
           3'd7, 3'd7, 1, 1, 1, 524287, 524287);
    do_mix("sat_neg", pack(-400000, -400000, -400000, -400000), 4'b1111, 4'b1111,
           3'd7, 3'd7, 1, 1, 1, -524288, -524288);

    // Overrun: second strobe two cycles after the first.
    @(negedge clk);
    samples = pack(1000, -300, 0, 0); pan1 = 4'b0001; pan2 = 4'b0011; vol1 = 3'd7; vol2 = 3'd7;
    strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    @(negedge clk); strobe = 1'b1; samples = pack(5, 5, 5, 5); pan1 = 4'b1111;
    @(negedge clk); strobe = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid) begin
        cnt++;
        chk("ovr_so1", longint'($signed(so1)), 1000);
        chk("ovr_so2", longint'($signed(so2)), 700);
      end
    end
    chk("ovr_pulses", cnt, 1);
    chk("ovr_set", ovr, 1);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("ovr_clear", ovr, 0);

    // Strobe held across the DONE cycle and the following IDLE cycle.
    samples = pack(1000, -300, 0, 0); pan1 = 4'b0001; pan2 = 4'b0011;
    strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    repeat (5) @(negedge clk);
    strobe = 1'b1;
    @(negedge clk);
    chk("done_valid", valid, 1);
    samples = pack(-2000, 0, 0, 0);
    @(negedge clk); strobe = 1'b0;
    chk("done_ovr", ovr, 1);
    cnt = 0;
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      if (valid) begin
        cnt++;
        chk("after_done_lat", i, 7);
        chk("after_done_so1", longint'($signed(so1)), -2000);
        chk("after_done_so2", longint'($signed(so2)), -2000);
      end
    end
    chk("after_done_pulses", cnt, 1);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;

    // Inputs change during accumulation; result follows the snapshot.
    samples = pack(1000, -300, 0, 0); pan1 = 4'b0001; pan2 = 4'b0011;
    strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      samples = pack(longint'($urandom_range(0, 500000)), 77, -77, 12345);
      pan1 = 4'b1111;
      @(negedge clk);
      if (valid) begin
        cnt++;
        chk("snap_so1", longint'($signed(so1)), 1000);
        chk("snap_so2", longint'($signed(so2)), 700);
      end
    end
    chk("snap_pulses", cnt, 1);

    // Reset during the second accumulation cycle.
    pan1 = 4'b0001;
    strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_so1", so1, 0);
    chk("midrst_so2", so2, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (valid) cnt++; end
    chk("midrst_no_valid", cnt, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 3) == 0) samples[k*SW +: SW] = SW'($urandom_range(0, 2000) - 1000);
        else samples[k*SW +: SW] = SW'($urandom);
      end
      pan1   = NUM_CH'($urandom);
      pan2   = NUM_CH'($urandom);
      vol1   = 3'($urandom);
      vol2   = 3'($urandom);
      en1    = ($urandom_range(0, 7) != 0);
      en2    = ($urandom_range(0, 7) != 0);
      men    = ($urandom_range(0, 7) != 0);
      strobe = ($urandom_range(0, 3) == 0);
      clr    = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    strobe = 1'b0;
    clr = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gbc_sound_mixer.md
# gbc_sound_mixer

Parametrised, time-multiplexed stereo mixer for the GBC sound subsystem. Sits between the per-channel sound generators and the AC97 output path. On each sample request it snapshots all channel samples and NR50/NR51/NR52-derived controls, then accumulates the panned channels one per cycle. It applies the 3-bit per-terminal master volume and saturates to the output width, producing one SO1/SO2 sample pair per request.

## Interface
- NUM_CH, 4, number of sound channels (1..16)
- SAMPLE_W, 20, signed two's-complement width of each channel sample and of each output
- I_CLK  in  1  system clock; all state on rising edge
- I_RESET_L  in  1  asynchronous, active-low reset
- I_STROBE  in  1  sample request, single-cycle pulse synchronous to I_CLK
- I_CH_SAMPLES  in  NUM_CH*SAMPLE_W  channel k at bits [k*SAMPLE_W +: SAMPLE_W], signed
- I_PAN_SO1  in  NUM_CH  bit k routes channel k to SO1 (NR51[3:0] layout for NUM_CH=4)
- I_PAN_SO2  in  NUM_CH  bit k routes channel k to SO2 (NR51[7:4])
- I_SO1_VOL, I_SO2_VOL  in  3 each  master volume 0..7 (NR50[2:0], NR50[6:4])
- I_SO1_EN, I_SO2_EN  in  1 each  terminal output enable (NR50[3], NR50[7])
- I_MASTER_EN  in  1  all-sound enable (NR52[7])
- I_CLR_OVERRUN  in  1  clears O_OVERRUN
- O_SO1, O_SO2  out  SAMPLE_W  mixed signed samples, held until the next O_VALID
- O_VALID  out  1  one-cycle pulse when O_SO1/O_SO2 update
- O_BUSY  out  1  high while a mix is in progress
- O_OVERRUN  out  1  sticky; a strobe arrived while busy

## Operation
- States: IDLE, ACCUM, SCALE, DONE.
- IDLE: I_STROBE=1 snapshots all data and control inputs into internal registers, clears both accumulators, sets channel index to 0, goes to ACCUM. Inputs are not sampled again until the next accepted strobe.
- ACCUM: each cycle adds sign-extended snapshot sample[idx] to ACC1 if pan_so1[idx], and to ACC2 if pan_so2[idx]. idx increments. After idx = NUM_CH-1, goes to SCALE. Exactly NUM_CH cycles.
- SCALE: each product P = ACC * (VOL+1), computed signed. Then arithmetic shift right by 3, so vol 7 is unity and vol 0 is 1/8. Results are clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. A result is forced to 0 if its terminal enable or the master enable is 0 in the snapshot. Goes to DONE.
- DONE: O_SO1/O_SO2 load the SCALE results, O_VALID=1 for this cycle, returns to IDLE.
- Widths: ACC_W = SAMPLE_W + $clog2(NUM_CH) + 1, so no accumulator overflow is possible. Product width is ACC_W + 4. Saturation happens only in SCALE; the per-channel pre-divide is removed.
- Strobe while O_BUSY=1: ignored, the current mix is unaffected, and O_OVERRUN sets. The O_OVERRUN set takes priority over a same-cycle I_CLR_OVERRUN.
- A strobe in the DONE cycle counts as busy and is ignored.
- A strobe in the first IDLE cycle after DONE is accepted.

## Timing
- Reset (async, I_RESET_L=0) forces the following immediately, independent of I_CLK: state IDLE; O_SO1=0, O_SO2=0, O_VALID=0, O_BUSY=0, O_OVERRUN=0; accumulators 0; idx 0.
- Reset mid-mix aborts the mix; no O_VALID follows deassertion.
- Latency: with a strobe sampled at edge t, O_VALID is high in the cycle after edge t+NUM_CH+2 (6 cycles for NUM_CH=4). O_SO1/O_SO2 take their new values at that same edge.
- O_BUSY is high from edge t through the DONE cycle inclusive. Total busy = NUM_CH+2 cycles.
- Minimum accepted strobe spacing is NUM_CH+3 cycles. An AC97 48 kHz strobe at any I_CLK ≥ 1 MHz never overruns.
- O_VALID is never high for two consecutive cycles.

## Test plan
All scenarios use NUM_CH=4, SAMPLE_W=20, and master and terminal enables high unless stated.
- Reset: hold I_RESET_L=0, then release without strobe -> all outputs 0, O_BUSY=0, no O_VALID for 20 cycles.
- Routing/latency: ch0=1000, ch1=-300, PAN_SO1=0001, PAN_SO2=0011, vols 7, strobe at edge t -> O_VALID only after edge t+6. O_SO1=1000, O_SO2=700. Repeat with I_SO2_EN=0 -> O_SO2=0. Repeat with I_MASTER_EN=0 -> both 0, O_VALID still pulses.
- Volume: ch0=800 on SO1 with vol 3 -> O_SO1=400. ch0=-800 with vol 0 -> O_SO1=-100.
- Saturation: all four channels 400000 on both, vol 7 -> O_SO1=O_SO2=524287. All four -400000 -> both -524288.
- Overrun: strobe, then a second strobe 2 cycles later -> single O_VALID with the first snapshot's result, O_OVERRUN=1. Pulse I_CLR_OVERRUN -> 0. A strobe in the DONE cycle is ignored; a strobe one cycle later is accepted.
- Mid-mix reset plus snapshot: change I_CH_SAMPLES during ACCUM -> result reflects the snapshot values. In a separate run, assert I_RESET_L=0 in the second ACCUM cycle -> outputs 0 at once, no O_VALID after release.
